// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply command sequencer for one modmult instance.
// PRELOAD 1 cycle after start, next command 2 cycles after each ack, done 2 cycles after STORE ack.
module modexp_sequencer #(
  parameter int E_WIDTH     = 32,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         aclr_n,
  input  logic                         start,
  input  logic [E_WIDTH-1:0]           exp,
  input  logic [$clog2(E_WIDTH+1)-1:0] exp_len,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [2:0]                   command,
  input  logic                         command_ack
);
  localparam int LW = $clog2(E_WIDTH + 1);
  localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [2:0] CMD_NOP     = 3'b000;
  localparam logic [2:0] CMD_MULT    = 3'b010;
  localparam logic [2:0] CMD_SQUARE  = 3'b011;
  localparam logic [2:0] CMD_PRELOAD = 3'b100;
  localparam logic [2:0] CMD_STORE   = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t                r_state;
  logic [E_WIDTH-1:0]    r_exp;
  logic signed [LW:0]    r_idx;
  logic [2:0]            r_op;
  logic                  r_sent;
  logic [TW-1:0]         r_tmo_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [2:0]            r_cmd;

  logic                  w_len_bad;
  logic                  w_tmo_hit;
  logic                  w_bit;
  logic signed [LW:0]    w_idx_dec;
  logic signed [LW:0]    w_next_idx;
  logic [2:0]            w_next_op;

  assign w_len_bad = (exp_len == '0) || (32'(exp_len) > 32'(E_WIDTH));
  assign w_tmo_hit = (ACK_TIMEOUT > 0) && ((32'(r_tmo_cnt) + 32'd1) == 32'(ACK_TIMEOUT));
  assign w_bit     = r_exp[r_idx[IW-1:0]];
  assign w_idx_dec = r_idx - $signed((LW+1)'(1));

  // The index MSB is its sign: a negative index means all bits are consumed.
  always_comb begin
    w_next_idx = r_idx;
    w_next_op  = CMD_STORE;
    case (r_op)
      CMD_SQUARE: begin
        if (w_bit) begin
          w_next_op = CMD_MULT;
        end else begin
          w_next_idx = w_idx_dec;
          w_next_op  = w_idx_dec[LW] ? CMD_STORE : CMD_SQUARE;
        end
      end
      CMD_MULT: begin
        w_next_idx = w_idx_dec;
        w_next_op  = w_idx_dec[LW] ? CMD_STORE : CMD_SQUARE;
      end
      default: begin
        w_next_op = r_idx[LW] ? CMD_STORE : CMD_SQUARE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state   <= S_IDLE;
      r_exp     <= '0;
      r_idx     <= '0;
      r_op      <= CMD_NOP;
      r_sent    <= 1'b0;
      r_tmo_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cmd     <= CMD_NOP;
    end else begin
      r_done <= 1'b0;
      r_cmd  <= CMD_NOP;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_exp  <= exp;
            r_idx  <= $signed({1'b0, exp_len}) - $signed((LW+1)'(2));
            r_op   <= CMD_PRELOAD;
            r_busy <= 1'b1;
            r_err  <= 1'b0;
            if (w_len_bad) begin
              r_state <= S_FIN;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_cmd   <= CMD_PRELOAD;
              r_sent  <= 1'b1;
            end
          end
        end
        // Two ISSUE cycles after an ack: the first loads the command, the second is the pulse.
        S_ISSUE: begin
          r_tmo_cnt <= '0;
          if (r_sent) begin
            r_sent  <= 1'b0;
            r_state <= S_WAIT;
          end else begin
            r_cmd  <= r_op;
            r_sent <= 1'b1;
          end
        end
        S_WAIT: begin
          r_tmo_cnt <= r_tmo_cnt + TW'(1);
          if (command_ack) begin
            if (r_op == CMD_STORE) begin
              r_state <= S_FIN;
            end else begin
              r_op    <= w_next_op;
              r_idx   <= w_next_idx;
              r_state <= S_ISSUE;
            end
          end else if (w_tmo_hit) begin
            r_state <= S_FIN;
            r_err   <= 1'b1;
          end
        end
        default: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign command = r_cmd;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Directed bench for modexp_sequencer: fixed-delay, timeout, reset, disturbance and random-delay runs.
module tb_modexp_sequencer;
  localparam int EW = 32;
  localparam int LW = 6;
  localparam logic [2:0] NOP = 3'b000, MUL = 3'b010, SQR = 3'b011, PRE = 3'b100, STO = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aclr_n = 1'b0;
  logic          start = 1'b0, start_t = 1'b0;
  logic          resp_ack = 1'b0, inj_ack = 1'b0;
  logic          command_ack;
  logic [EW-1:0] exp_v = '0;
  logic [LW-1:0] len_v = '0;
  logic          busy, done, err, busy_t, done_t, err_t;
  logic [2:0]    command, command_t;

  assign command_ack = resp_ack | inj_ack;

  modexp_sequencer #(.E_WIDTH(EW), .ACK_TIMEOUT(4096)) u_dut (
    .clk(clk), .aclr_n(aclr_n), .start(start), .exp(exp_v), .exp_len(len_v),
    .busy(busy), .done(done), .err(err), .command(command), .command_ack(command_ack)
  );

  modexp_sequencer #(.E_WIDTH(EW), .ACK_TIMEOUT(16)) u_tmo (
    .clk(clk), .aclr_n(aclr_n), .start(start_t), .exp(exp_v), .exp_len(len_v),
    .busy(busy_t), .done(done_t), .err(err_t), .command(command_t), .command_ack(command_ack)
  );

  int         n_chk = 0, n_err = 0;
  int         resp_cnt = 0, fixed_dly = 5, done_cnt = 0;
  bit         rand_dly = 1'b0, hold_sq = 1'b0, tmo_sel = 1'b0;
  logic [2:0] log_q[$], logt_q[$], expq[$];
  logic [2:0] first_cmd;
  logic       first_busy;

  // Responder: acks each command pulse after a programmable number of cycles.
  always @(posedge clk) begin
    logic [2:0] mc;
    #1;
    mc = tmo_sel ? command_t : command;
    resp_ack = 1'b0;
    if (!aclr_n) begin
      resp_cnt = 0;
    end else if (resp_cnt != 0) begin
      resp_cnt--;
      if (resp_cnt == 0) resp_ack = 1'b1;
    end else if (mc != NOP && !(hold_sq && mc == SQR)) begin
      resp_cnt = rand_dly ? int'($urandom_range(1, 50)) : fixed_dly;
    end
  end

  always @(posedge clk) begin
    #1;
    if (command != NOP) log_q.push_back(command);
    if (command_t != NOP) logt_q.push_back(command_t);
    if (done) done_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit seq_match(input logic [2:0] a[$], input logic [2:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[k]) if (a[k] !== b[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_req(input logic [31:0] e, input int len, input bit use_t, input bit disturb,
                         input int limit, output int n, output bit ok);
    log_q.delete();
    logt_q.delete();
    exp_v = e;
    len_v = LW'(len);
    if (use_t) start_t = 1'b1; else start = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (n < limit) begin
      step();
      n++;
      if (n == 1) begin
        first_cmd  = use_t ? command_t : command;
        first_busy = use_t ? busy_t : busy;
      end
      start_t = 1'b0;
      start   = disturb && (n == 20 || n == 49);
      inj_ack = disturb && (n == 8);
      if (use_t ? done_t : done) begin
        ok = 1'b1;
        break;
      end
    end
    start   = 1'b0;
    start_t = 1'b0;
    inj_ack = 1'b0;
  endtask

  initial begin
    int         n, len, pc;
    bit         ok;
    logic [31:0] e;
    logic [2:0] s1[$];
    s1 = '{PRE, SQR, SQR, MUL, SQR, MUL, STO};

    step();
    step();
    check("reset_outs", {command, busy, done, err}, 0);
    check("reset_outs_t", {command_t, busy_t, done_t, err_t}, 0);
    aclr_n = 1'b1;
    step();

    // Scenario 1: exp=0xB, len=4, 5-cycle ack delay; pulses at 1+7k, done at 50.
    run_req(32'hB, 4, 1'b0, 1'b0, 200, n, ok);
    check("s1_first_cmd", first_cmd, PRE);
    check("s1_first_busy", first_busy, 1);
    check("s1_done_lat", n, 50);
    check("s1_stream", seq_match(log_q, s1), 1);
    check("s1_err", err, 0);
    check("s1_busy_at_done", busy, 0);
    step();
    check("s1_done_pulse", done, 0);

    // Scenario 2: shortest valid and invalid lengths.
    run_req(32'h1, 1, 1'b0, 1'b0, 200, n, ok);
    check("s2_len1_lat", n, 15);
    check("s2_len1_stream", seq_match(log_q, '{PRE, STO}), 1);
    check("s2_len1_err", err, 0);
    step();
    run_req(32'h5, 0, 1'b0, 1'b0, 20, n, ok);
    check("s2_len0_lat", n, 2);
    check("s2_len0_err", err, 1);
    check("s2_len0_cmds", log_q.size(), 0);
    step();
    run_req(32'hFFFF_FFFF, 33, 1'b0, 1'b0, 20, n, ok);
    check("s2_len33_lat", n, 2);
    check("s2_len33_err", err, 1);
    check("s2_len33_cmds", log_q.size(), 0);
    step();
    check("s2_err_held", err, 1);

    // Scenario 3: ACK_TIMEOUT=16 instance, SQUARE never acked.
    tmo_sel   = 1'b1;
    hold_sq   = 1'b1;
    fixed_dly = 1;
    run_req(32'hB, 4, 1'b1, 1'b0, 100, n, ok);
    check("s3_tmo_lat", n, 22);
    check("s3_tmo_err", err_t, 1);
    check("s3_tmo_stream", seq_match(logt_q, '{PRE, SQR}), 1);
    check("s3_tmo_busy", busy_t, 0);
    step();
    check("s3_cmd_nop", command_t, NOP);
    tmo_sel   = 1'b0;
    hold_sq   = 1'b0;
    fixed_dly = 5;
    repeat (3) step();

    // Scenario 4: reset during WAIT of the third command.
    log_q.delete();
    exp_v = 32'hB;
    len_v = 6'd4;
    start = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      start = 1'b0;
    end
    check("s4_busy_pre", busy, 1);
    check("s4_cmds_pre", log_q.size(), 3);
    aclr_n = 1'b0;
    #1;
    check("s4_rst_outs", {command, busy, done, err}, 0);
    step();
    step();
    aclr_n   = 1'b1;
    done_cnt = 0;
    repeat (60) step();
    check("s4_no_done", done_cnt, 0);
    check("s4_idle", {command, busy}, 0);
    check("s4_no_cmds", log_q.size(), 3);
    run_req(32'hB, 4, 1'b0, 1'b0, 200, n, ok);
    check("s4_rerun_lat", n, 50);
    check("s4_rerun_stream", seq_match(log_q, s1), 1);
    step();

    // Scenario 5: ack while idle, start while busy/FIN, ack coincident with a pulse.
    inj_ack = 1'b1;
    step();
    inj_ack = 1'b0;
    step();
    check("s5_idle_ack", {command, busy}, 0);
    run_req(32'hB, 4, 1'b0, 1'b1, 200, n, ok);
    check("s5_done_lat", n, 50);
    check("s5_stream", seq_match(log_q, s1), 1);
    check("s5_err", err, 0);
    repeat (3) step();
    check("s5_no_requeue", {command, busy}, 0);
    check("s5_no_extra_cmds", log_q.size(), 7);

    // Scenario 6: random exponents and ack delays against a reference sequence.
    rand_dly = 1'b1;
    for (int r = 0; r < 8; r++) begin
      e   = $urandom;
      len = (r == 0) ? 32 : (r == 1) ? 2 : int'($urandom_range(1, 32));
      expq.delete();
      expq.push_back(PRE);
      for (int b = len - 2; b >= 0; b--) begin
        expq.push_back(SQR);
        if (e[b]) expq.push_back(MUL);
      end
      expq.push_back(STO);
      pc = 0;
      for (int b = 0; b < len - 1; b++) pc += int'(e[b]);
      run_req(e, len, 1'b0, 1'b0, 4000, n, ok);
      check("s6_done_seen", ok, 1);
      check("s6_count", log_q.size(), 2 + (len - 1) + pc);
      check("s6_stream", seq_match(log_q, expq), 1);
      check("s6_err", err, 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/modexp_sequencer.md
Name: modexp_sequencer

Overview:
- Command-side initiator for the modular multiplier.
- Drives its 3-bit command port and consumes command_ack to run a left-to-right square-and-multiply exponentiation.
- Sequence per request: PRELOAD, then SQUARE (and MULT on each 1 bit) for each exponent bit below the leading one, then STORE.
- Sits between the multiexp scheduler, which supplies exponent chunks, and one modmult instance.

Parameters:
- E_WIDTH, 32: maximum exponent width in bits.
- ACK_TIMEOUT, 4096: cycles to wait for command_ack before aborting. 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- aclr_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse. Accepted only when busy=0.
- exp  input  E_WIDTH  exponent. Bit exp_len-1 is the leading one.
- exp_len  input  $clog2(E_WIDTH+1)  number of significant exponent bits.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: invalid exp_len or ack timeout.
- command  output  3  to modmult. NOP=3'b000, BEGINMULT=3'b010, BEGINSQUARE=3'b011, PRELOAD=3'b100, STORE=3'b101.
- command_ack  input  1  from modmult: one-cycle pulse when the current operation completes.

Behaviour:
- Reset: asynchronous on aclr_n low. command=NOP, busy=0, done=0, err=0, FSM=IDLE, counters cleared. Reset mid-operation abandons the request silently; no done is produced.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, FIN.
- IDLE:
  - start=1 latches exp and exp_len, loads bit index i=exp_len-2, and sets pending op=PRELOAD.
  - If exp_len==0 or exp_len>E_WIDTH, go to FIN with err=1 and issue no commands.
  - Otherwise go to ISSUE.
  - command_ack in IDLE is ignored.
- ISSUE:
  - command=pending op for exactly one cycle, then NOP.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - command=NOP. command_ack is sampled starting the cycle after the command pulse; an ack coincident with the pulse is ignored.
  - On ack, choose the next op:
    - After PRELOAD or MULT: if i>=0, next is SQUARE; otherwise next is STORE.
    - After SQUARE: if exp[i]=1, next is MULT with i unchanged. If exp[i]=0, decrement i; next is SQUARE if the new i>=0, else STORE. After the MULT ack, decrement i and apply the "after MULT" rule.
    - After STORE: go to FIN with err=0.
    - In all non-STORE cases, go to ISSUE.
  - Track i as signed, one bit wider than exp_len.
- Timeout: if ACK_TIMEOUT>0 and the counter reaches ACK_TIMEOUT with no ack, go to FIN with err=1. No STORE is issued.
- FIN:
  - done=1 for one cycle; err is held valid during that cycle.
  - busy=0 in the same cycle. Next state is IDLE.
  - err clears when the next start is accepted.
- busy timing: busy rises the cycle after start is accepted and stays high through ISSUE and WAIT.
- start while busy or in FIN is ignored and not queued.
- Latency: command=PRELOAD appears 1 cycle after start. Each next command appears 2 cycles after the previous ack. done appears 2 cycles after the STORE ack.
- Command count for a valid request: 2 + (exp_len-1) + popcount(exp[exp_len-2:0]).

Test Plan:
1. Ack responder at 5 cycles; exp=32'hB, exp_len=4. Command stream must be PRELOAD, SQ, SQ, MULT, SQ, MULT, STORE (7 pulses), then done=1, err=0.
2. exp_len=1, exp=1. Stream must be PRELOAD, STORE. Then exp_len=0: no command pulses; done=1 and err=1 two cycles after start.
3. ACK_TIMEOUT=16; the responder withholds the ack after the first SQUARE. Stream must be PRELOAD, SQ, then NOP only; done=1, err=1 after 16 WAIT cycles.
4. Pulse aclr_n low during WAIT of the 3rd command. command, busy, done and err must read 0 immediately, with no done afterwards. A new start must then run cleanly.
5. Pulse start while busy and pulse command_ack while idle. Neither may disturb the stream of scenario 1. Inject an ack coincident with a command pulse: it must be ignored and the FSM must wait for a later ack.
6. Random exp values at E_WIDTH=32 with random ack delays of 1–50 cycles. A reference model of the command sequence must match, and the command count must equal 2+(exp_len-1)+popcount.
